// File: rtl/eth_tx_pkg.sv
// Shared types, byte constants, default sizing and CRC-32 byte step for the GMII TX framer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] PAD_BYTE      = 8'h00;

    localparam int unsigned DEF_PREAMBLE_BYTES = 7;
    localparam int unsigned DEF_IFG_BYTES      = 12;
    localparam int unsigned DEF_MIN_FRAME      = 60;
    localparam int unsigned DEF_MAX_FRAME      = 1514;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned CYC_W = 8;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // Reflected CRC-32 (IEEE 802.3) update by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Ethernet FCS generator: one byte per enabled cycle. crc_out already
// includes din when en is high, and is byte-ordered so crc_out[31:24] is
// the first FCS byte on the wire.
module crc
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [31:0] crc_fin;

    // Next remainder including the presented byte.
    always_comb begin
        crc_nxt = crc32_byte(crc_q, din);
    end

    // Remainder register, re-seeded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_nxt;
        end
    end

    assign crc_fin = ~(en ? crc_nxt : crc_q);
    assign crc_out = {crc_fin[7:0], crc_fin[15:8], crc_fin[23:16], crc_fin[31:24]};

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional zero padding,
// FCS and inter-frame gap. Padding to MIN_FRAME is built only when
// ETH_TX_PAD_EN is defined; otherwise short frames go out unpadded.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
    parameter int unsigned IFG_BYTES      = DEF_IFG_BYTES,
    parameter int unsigned MIN_FRAME      = DEF_MIN_FRAME,
    parameter int unsigned MAX_FRAME      = DEF_MAX_FRAME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] abort_count
);

    // A frame may never be forced to abort before it could have been padded.
    localparam int unsigned MAX_LEN = (MAX_FRAME > MIN_FRAME) ? MAX_FRAME : MIN_FRAME;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
`ifdef ETH_TX_PAD_EN
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
`endif
    localparam logic [CYC_W-1:0] PRE_CNT  = CYC_W'(PREAMBLE_BYTES);
    localparam logic [CYC_W-1:0] IFG_LAST = CYC_W'(IFG_BYTES - 1);

    state_t           state, state_next;
    logic [CYC_W-1:0] cyc_cnt, cyc_next;
    logic [CNT_W-1:0] byte_cnt, byte_next;
    logic [31:0]      fcs, fcs_next;
    logic [7:0]       txd_d;
    logic             en_d;
    logic             er_d;
    logic             ready_d;
    logic             frame_inc;
    logic             abort_inc;
    logic             crc_en;
    logic [7:0]       crc_din;
    logic             crc_clear;
    logic [31:0]      crc_out;

    // CRC is re-seeded by global reset and throughout the inter-frame gap.
    crc u_crc (
        .clk     (clk),
        .reset   (reset | crc_clear),
        .en      (crc_en),
        .din     (crc_din),
        .crc_out (crc_out)
    );

    // State, counters and registered pin drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            byte_cnt    <= '0;
            fcs         <= '0;
            gmii_txd    <= '0;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            abort_count <= '0;
        end else begin
            state      <= state_next;
            cyc_cnt    <= cyc_next;
            byte_cnt   <= byte_next;
            fcs        <= fcs_next;
            gmii_txd   <= txd_d;
            gmii_tx_en <= en_d;
            gmii_tx_er <= er_d;
            s_ready    <= ready_d;
            busy       <= (state_next != S_IDLE);
            if (frame_inc) begin
                frame_count <= frame_count + 16'd1;
            end
            if (abort_inc) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end

    // Next state plus the byte to put on the wire next cycle.
    always_comb begin
        state_next = state;
        cyc_next   = cyc_cnt;
        byte_next  = byte_cnt;
        fcs_next   = fcs;
        txd_d      = PAD_BYTE;
        en_d       = 1'b0;
        er_d       = 1'b0;
        frame_inc  = 1'b0;
        abort_inc  = 1'b0;
        crc_en     = 1'b0;
        crc_din    = PAD_BYTE;
        crc_clear  = 1'b0;

        unique case (state)
            S_IDLE: begin
                byte_next = '0;
                if (s_valid) begin
                    state_next = S_PREAMBLE;
                    cyc_next   = CYC_W'(1);
                    txd_d      = PREAMBLE_BYTE;
                    en_d       = 1'b1;
                end
            end

            S_PREAMBLE: begin
                en_d = 1'b1;
                if (cyc_cnt >= PRE_CNT) begin
                    state_next = S_SFD;
                    txd_d      = SFD_BYTE;
                end else begin
                    cyc_next = cyc_cnt + CYC_W'(1);
                    txd_d    = PREAMBLE_BYTE;
                end
            end

            S_SFD, S_DATA: begin
                en_d = 1'b1;
                if (!s_valid || byte_cnt == MAX_CNT) begin
                    // Underrun or oversize: one error byte, then gap.
                    state_next = S_IFG;
                    cyc_next   = '0;
                    er_d       = 1'b1;
                    txd_d      = PAD_BYTE;
                    abort_inc  = 1'b1;
                end else begin
                    state_next = S_DATA;
                    txd_d      = s_data;
                    crc_en     = 1'b1;
                    crc_din    = s_data;
                    byte_next  = byte_cnt + CNT_W'(1);
                    if (s_last) begin
`ifdef ETH_TX_PAD_EN
                        if (byte_next < MIN_CNT) begin
                            state_next = S_PAD;
                        end else begin
                            state_next = S_FCS;
                            cyc_next   = '0;
                            fcs_next   = crc_out;
                        end
`else
                        state_next = S_FCS;
                        cyc_next   = '0;
                        fcs_next   = crc_out;
`endif
                    end
                end
            end

`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                en_d      = 1'b1;
                txd_d     = PAD_BYTE;
                crc_en    = 1'b1;
                crc_din   = PAD_BYTE;
                byte_next = byte_cnt + CNT_W'(1);
                if (byte_next >= MIN_CNT) begin
                    state_next = S_FCS;
                    cyc_next   = '0;
                    fcs_next   = crc_out;
                end
            end
`endif

            S_FCS: begin
                en_d = 1'b1;
                unique case (cyc_cnt[1:0])
                    2'd0:    txd_d = fcs[31:24];
                    2'd1:    txd_d = fcs[23:16];
                    2'd2:    txd_d = fcs[15:8];
                    default: txd_d = fcs[7:0];
                endcase
                if (cyc_cnt[1:0] == 2'd3) begin
                    state_next = S_IFG;
                    cyc_next   = '0;
                    frame_inc  = 1'b1;
                end else begin
                    cyc_next = cyc_cnt + CYC_W'(1);
                end
            end

            S_IFG: begin
                crc_clear = 1'b1;
                if (cyc_cnt >= IFG_LAST) begin
                    state_next = S_IDLE;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_cnt + CYC_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                cyc_next   = '0;
            end
        endcase

        ready_d = (state_next == S_SFD) ||
                  ((state_next == S_DATA) && (byte_next != MAX_CNT));
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a wire-byte scoreboard and an
// independent bit-serial CRC-32 model. Follows ETH_TX_PAD_EN like the DUT.
module tb_eth_tx_framer;

    typedef logic [7:0] byte_t;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] abort_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic       prev_en  = 1'b0;
    int         run_cnt  = 0;
    int         idle_cnt = 0;
    int         last_run = 0;
    int         last_gap = 0;

    eth_tx_framer dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .frame_count (frame_count),
        .abort_count (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 over a byte list, final complement applied.
    function automatic logic [31:0] sw_crc(input byte_t q[$]);
        logic [31:0] c;
        logic        fb;
        byte_t       b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < q.size(); i++) begin
            b = q[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Expected wire image of a complete good frame.
    task automatic push_frame(input byte_t p[$]);
        byte_t       f[$];
        logic [31:0] c;
        f = p;
`ifdef ETH_TX_PAD_EN
        while (f.size() < 60) f.push_back(8'h00);
`endif
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (f[i]) exp_q.push_back({1'b0, f[i]});
        c = sw_crc(f);
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[31:24]});
    endtask

    task automatic push_head(input byte_t p[$]);
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (p[i]) exp_q.push_back({1'b0, p[i]});
    endtask

    // Drive bytes honouring s_ready; called and returns on a falling edge.
    task automatic send(input byte_t p[$], input bit with_last);
        int   i     = 0;
        int   guard = 0;
        logic hs;
        while (i < p.size() && guard < 4000) begin
            s_valid = 1'b1;
            s_data  = p[i];
            s_last  = with_last && (i == p.size() - 1);
            hs      = s_ready;
            @(negedge clk);
            guard++;
            if (hs) i++;
        end
        if (i < p.size()) check("send_timeout", 32'(i), 32'(p.size()));
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Wire monitor: every tx_en byte is popped from the scoreboard.
    always @(negedge clk) begin
        if (gmii_tx_en === 1'b1) begin
            if (!prev_en) last_gap = idle_cnt;
            idle_cnt = 0;
            run_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("wire_er_txd", {23'd0, gmii_tx_er, gmii_txd}, {23'd0, exp_q.pop_front()});
            end
        end else begin
            if (prev_en) last_run = run_cnt;
            run_cnt = 0;
            idle_cnt++;
            check("idle_wire", {23'd0, gmii_tx_er, gmii_txd}, 32'd0);
        end
        prev_en = gmii_tx_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        byte_t p[$];
        byte_t q[$];
        int    exp_run;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_pins", {20'd0, gmii_tx_en, gmii_tx_er, s_ready, busy, gmii_txd}, 32'd0);
        check("reset_counts", {frame_count, abort_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", {30'd0, s_ready, busy}, 32'd0);

        // "123456789"
        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        push_frame(p);
        send(p, 1'b1);
        wait_idle();
`ifdef ETH_TX_PAD_EN
        exp_run = 8 + 60 + 4;
`else
        exp_run = 8 + 9 + 4;
`endif
        check("run_len_9", 32'(last_run), 32'(exp_run));
        check("frame_count_1", 32'(frame_count), 32'd1);
        check("abort_count_0", 32'(abort_count), 32'd0);

        // 64-byte payload: never padded
        p = {};
        for (int i = 0; i < 64; i++) p.push_back(8'(i * 7 + 3));
        push_frame(p);
        send(p, 1'b1);
        wait_idle();
        check("run_len_64", 32'(last_run), 32'd76);
        check("frame_count_2", 32'(frame_count), 32'd2);

        // back-to-back frames with s_valid held
        p = {};
        q = {};
        for (int i = 0; i < 10; i++) p.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h10 + i * 3));
        push_frame(p);
        push_frame(q);
        send(p, 1'b1);
        send(q, 1'b1);
        wait_idle();
        check("ifg_gap", 32'(last_gap), 32'd12);
        check("frame_count_4", 32'(frame_count), 32'd4);

        // underrun after 20 payload bytes
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(8'(i + 1));
        push_head(p);
        exp_q.push_back({1'b1, 8'h00});
        send(p, 1'b0);
        wait_idle();
        check("run_len_underrun", 32'(last_run), 32'd29);
        check("abort_count_1", 32'(abort_count), 32'd1);
        check("frame_count_keep", 32'(frame_count), 32'd4);

        // reset while in DATA
        p = {};
        for (int i = 0; i < 5; i++) p.push_back(8'(8'h61 + i));
        push_head(p);
        send(p, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_pins", {20'd0, gmii_tx_en, gmii_tx_er, s_ready, busy, gmii_txd}, 32'd0);
        check("midreset_counts", {frame_count, abort_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // frame after reset: CRC must start fresh
        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h41 + i * 2));
        push_frame(p);
        send(p, 1'b1);
        wait_idle();
        check("frame_count_after_reset", 32'(frame_count), 32'd1);
        check("abort_count_after_reset", 32'(abort_count), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
